// File: rtl/i2c_apb_master_arbiter.sv
// Two-requester round-robin APB master in front of the I2C controller register port.
// Optional PREADY timeout guarded by APB_TIMEOUT_EN; default build waits forever with err tied low.
module i2c_apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       grant;
  logic       elig0;
  logic       elig1;
  logic       pick1;
  logic       timeout_hit;

  // A requester whose done is pulsing is still holding req from the finished transfer.
  assign elig0 = req0 & ~done0;
  assign elig1 = req1 & ~done1;
  assign pick1 = elig1 & (~elig0 | ~last_grant);

`ifdef APB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wait_cnt;

  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      PSELx      <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            grant  <= pick1;
            PWRITE <= pick1 ? we1 : we0;
            PADDR  <= pick1 ? addr1 : addr0;
            PWDATA <= pick1 ? wdata1 : wdata0;
            PSELx  <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY || timeout_hit) begin
            if (timeout_hit) begin
              rdata <= '0;
              err   <= 1'b1;
            end else if (!PWRITE) begin
              rdata <= PRDATA;
            end
            done0      <= ~grant;
            done1      <= grant;
            PSELx      <= 1'b0;
            PENABLE    <= 1'b0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_apb_master_arbiter.sv
// Directed bench for i2c_apb_master_arbiter: reset, write, wait-state read, contention, re-request, stall.
module tb_i2c_apb_master_arbiter;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req0, req1, we0, we1;
  logic [6:0] addr0, addr1, PADDR;
  logic [7:0] wdata0, wdata1, rdata, PWDATA, PRDATA;
  logic       done0, done1, err, PSELx, PENABLE, PWRITE, PREADY;

  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  i2c_apb_master_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge where a done pulse is visible; id = -1 on budget expiry.
  task automatic wait_done(output int id, input int budget);
    id = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      if (done0 && done1) check("both_done", 1, 0);
      if (done0) begin id = 0; return; end
      if (done1) begin id = 1; return; end
    end
    check("done_timeout", 1, 0);
  endtask

  int id;
  logic bad;

  initial begin
    PRESET = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    PRDATA = 0; PREADY = 1'b1;
    repeat (2) @(negedge PCLK);
    check("rst_psel", PSELx, 0);
    check("rst_pen", PENABLE, 0);
    check("rst_done", {done1, done0}, 0);
    check("rst_err", err, 0);
    check("rst_bus", {PWRITE, PADDR, PWDATA, rdata}, 0);
    PRESET = 1'b0;

    // Reset in the middle of ACCESS
    @(negedge PCLK);
    req0 = 1; we0 = 0; addr0 = 7'h05; PREADY = 0;
    @(negedge PCLK);
    check("t1_setup", {PSELx, PENABLE}, 2'b10);
    @(negedge PCLK);
    check("t1_access", {PSELx, PENABLE}, 2'b11);
    PRESET = 1'b1;
    #1;
    check("t1_async_drop", {PSELx, PENABLE}, 2'b00);
    @(negedge PCLK);
    check("t1_no_done", {done1, done0}, 0);
    req0 = 0; PRESET = 1'b0; PREADY = 1;
    @(negedge PCLK);
    check("t1_idle", {PSELx, PENABLE, done1, done0, err}, 0);
    check("t1_bus", {PWRITE, PADDR, PWDATA, rdata}, 0);

    // Read with three wait states
    req1 = 1; we1 = 0; addr1 = 7'h02; PREADY = 0; PRDATA = 8'hA5;
    @(negedge PCLK);
    check("t3_setup", {PSELx, PENABLE, PWRITE, PADDR}, {3'b100, 7'h02});
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("t3_access", {PSELx, PENABLE, done1}, 3'b110);
      if (i == 3) PREADY = 1;
    end
    @(negedge PCLK);
    check("t3_done", {done1, done0, PSELx, PENABLE}, 4'b1000);
    check("t3_rdata", rdata, 8'hA5);
    check("t3_err", err, 0);
    req1 = 0; PRDATA = 8'h3C;

    // Single write
    @(negedge PCLK);
    req0 = 1; we0 = 1; addr0 = 7'h0F; wdata0 = 8'h01;
    @(negedge PCLK);
    check("t2_setup", {PSELx, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 7'h0F, 8'h01});
    @(negedge PCLK);
    check("t2_access", {PSELx, PENABLE, PADDR, PWDATA, done0}, {2'b11, 7'h0F, 8'h01, 1'b0});
    @(negedge PCLK);
    check("t2_done", {done0, done1, err, PSELx}, 4'b1000);
    check("t2_rdata_keep", rdata, 8'hA5);
    req0 = 0;
    @(negedge PCLK);
    check("t2_pulse_end", done0, 0);

    // Contention from reset, both held: 0,1,0,1
    PRESET = 1;
    req0 = 1; we0 = 1; addr0 = 7'h11; wdata0 = 8'hAA;
    req1 = 1; we1 = 1; addr1 = 7'h22; wdata1 = 8'hBB;
    @(negedge PCLK);
    PRESET = 0;
    for (int n = 0; n < 4; n++) begin
      wait_done(id, 10);
      check("t4_order", id, n % 2);
      if (n == 3) begin req0 = 0; req1 = 0; end
      if (n == 0) begin
        @(negedge PCLK);
        check("t4_next_grant", {PSELx, PENABLE, PADDR, PWDATA}, {2'b10, 7'h22, 8'hBB});
      end
    end
    @(negedge PCLK);
    check("t4_quiet", PSELx, 0);

    // req0 held across done: one gap cycle, then a fresh transfer
    req0 = 1; we0 = 1; addr0 = 7'h33; wdata0 = 8'h44;
    wait_done(id, 10);
    check("t5_first", id, 0);
    @(negedge PCLK);
    check("t5_gap", {PSELx, done0}, 2'b00);
    @(negedge PCLK);
    check("t5_regrant", {PSELx, PENABLE, PADDR}, {2'b10, 7'h33});
    req0 = 0;
    wait_done(id, 10);
    check("t5_second", id, 0);
    @(negedge PCLK);
    check("t5_idle", {PSELx, done0}, 0);

    // PREADY stuck low
    req1 = 1; we1 = 0; addr1 = 7'h44; PREADY = 0; PRDATA = 8'h5A;
    @(negedge PCLK);
    @(negedge PCLK);
    check("t6_access", {PSELx, PENABLE}, 2'b11);
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("t6_waiting", {PSELx, PENABLE, done1}, 3'b110);
    end
    @(negedge PCLK);
    check("t6_to_done", {done1, err, PSELx, PENABLE}, 4'b1100);
    check("t6_to_rdata", rdata, 0);
    req1 = 0; PREADY = 1;
`else
    bad = 0;
    repeat (100) begin
      @(negedge PCLK);
      if (!PSELx || !PENABLE || done1 || done0 || err) bad = 1;
    end
    check("t6_hold", bad, 0);
    PREADY = 1;
    wait_done(id, 5);
    check("t6_late_id", id, 1);
    check("t6_late_rdata", rdata, 8'h5A);
    check("t6_late_err", err, 0);
    req1 = 0;
`endif
    @(negedge PCLK);
    check("t6_idle", {PSELx, PENABLE, done1, err}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
